// File: rtl/spi_sts_pkg.sv
// spi_sts_pkg: fault category codes and channel-index sizing shared by the status return path
package spi_sts_pkg;

    localparam logic [1:0] FAULT_NONE        = 2'd0;
    localparam logic [1:0] FAULT_OVER_THRESH = 2'd1;
    localparam logic [1:0] FAULT_UNDERFLOW   = 2'd2;
    localparam logic [1:0] FAULT_OVERFLOW    = 2'd3;

    function automatic int ch_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sts_field_filter.sv
// sts_field_filter: multi-flop synchroniser plus stability filter for one asynchronous status field
module sts_field_filter #(
    parameter int WIDTH        = 1,
    parameter int DEPTH        = 3,
    parameter int STABLE_COUNT = 2
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] value,
    output logic             stable
);

    localparam int               CNT_W   = $clog2(STABLE_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_COUNT);

    logic [DEPTH-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]            prev;
    logic [CNT_W-1:0]            cnt;

    assign value  = sync_q[DEPTH-1];
    assign stable = (cnt == CNT_MAX) && (value == prev);

    // shift the raw input through the synchroniser stages
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn)
            sync_q <= '0;
        else
            sync_q <= {sync_q[DEPTH-2:0], din};

    // track how long the synchronised value has stayed unchanged, saturating at the threshold
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            prev <= '0;
            cnt  <= '0;
        end else begin
            prev <= value;
            cnt  <= (value != prev) ? '0 : (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        end

endmodule

// File: rtl/spi_sts_sync.sv
// spi_sts_sync: brings SPI-domain status into aclk, filters it, and keeps sticky faults with first-fault capture
module spi_sts_sync
    import spi_sts_pkg::*;
#(
    parameter  int N_CH         = 8,
    parameter  int DEPTH        = 3,
    parameter  int STABLE_COUNT = 2,
    localparam int CH_W         = ch_w(N_CH)
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic            spi_running_in,
    input  logic [31:0]     trig_count_in,
    input  logic [N_CH-1:0] over_thresh_in,
    input  logic [N_CH-1:0] buf_underflow_in,
    input  logic [N_CH-1:0] buf_overflow_in,
    input  logic            sts_clear,
    output logic            spi_running,
    output logic [31:0]     trig_count,
    output logic [N_CH-1:0] over_thresh_sticky,
    output logic [N_CH-1:0] buf_underflow_sticky,
    output logic [N_CH-1:0] buf_overflow_sticky,
    output logic [1:0]      first_fault_code,
    output logic [CH_W-1:0] first_fault_ch,
    output logic            fault_irq
);

    logic            run_v, run_s, cnt_s, ot_s, uf_s, of_s;
    logic [31:0]     cnt_v;
    logic [N_CH-1:0] ot_v, uf_v, of_v;
    logic [N_CH-1:0] ot_set, uf_set, of_set;
    logic [N_CH-1:0] ot_nxt, uf_nxt, of_nxt;
    logic [N_CH-1:0] ff_vec;
    logic            any_old, any_set, capture;
    logic [1:0]      ff_code;

    function automatic logic [CH_W-1:0] low_idx(input logic [N_CH-1:0] v);
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--)
            if (v[i]) r = CH_W'(i);
        return r;
    endfunction

    sts_field_filter #(.WIDTH(1), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_run (
        .aclk(aclk), .aresetn(aresetn), .din(spi_running_in), .value(run_v), .stable(run_s));
    sts_field_filter #(.WIDTH(32), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_cnt (
        .aclk(aclk), .aresetn(aresetn), .din(trig_count_in), .value(cnt_v), .stable(cnt_s));
    sts_field_filter #(.WIDTH(N_CH), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_ot (
        .aclk(aclk), .aresetn(aresetn), .din(over_thresh_in), .value(ot_v), .stable(ot_s));
    sts_field_filter #(.WIDTH(N_CH), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_uf (
        .aclk(aclk), .aresetn(aresetn), .din(buf_underflow_in), .value(uf_v), .stable(uf_s));
    sts_field_filter #(.WIDTH(N_CH), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_of (
        .aclk(aclk), .aresetn(aresetn), .din(buf_overflow_in), .value(of_v), .stable(of_s));

    // a clear drops old sticky state but a set arriving the same cycle still lands
    assign ot_set  = ot_s ? ot_v : '0;
    assign uf_set  = uf_s ? uf_v : '0;
    assign of_set  = of_s ? of_v : '0;
    assign ot_nxt  = (sts_clear ? '0 : over_thresh_sticky) | ot_set;
    assign uf_nxt  = (sts_clear ? '0 : buf_underflow_sticky) | uf_set;
    assign of_nxt  = (sts_clear ? '0 : buf_overflow_sticky) | of_set;
    assign any_old = !sts_clear && |{over_thresh_sticky, buf_underflow_sticky, buf_overflow_sticky};
    assign any_set = |{ot_set, uf_set, of_set};
    assign capture = !any_old && any_set;
    assign ff_code = |ot_set ? FAULT_OVER_THRESH : |uf_set ? FAULT_UNDERFLOW : FAULT_OVERFLOW;
    assign ff_vec  = |ot_set ? ot_set : |uf_set ? uf_set : of_set;

    // publish level fields only while their filtered value is settled
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            spi_running <= 1'b0;
            trig_count  <= '0;
        end else begin
            if (run_s) spi_running <= run_v;
            if (cnt_s) trig_count <= cnt_v;
        end

    // accumulate sticky faults and drive the level interrupt from their next value
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            over_thresh_sticky   <= '0;
            buf_underflow_sticky <= '0;
            buf_overflow_sticky  <= '0;
            fault_irq            <= 1'b0;
        end else begin
            over_thresh_sticky   <= ot_nxt;
            buf_underflow_sticky <= uf_nxt;
            buf_overflow_sticky  <= of_nxt;
            fault_irq            <= |{ot_nxt, uf_nxt, of_nxt};
        end

    // record the first fault seen since the last clear; priority by category then lowest channel
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            first_fault_code <= FAULT_NONE;
            first_fault_ch   <= '0;
        end else if (capture) begin
            first_fault_code <= ff_code;
            first_fault_ch   <= low_idx(ff_vec);
        end else if (sts_clear) begin
            first_fault_code <= FAULT_NONE;
            first_fault_ch   <= '0;
        end

endmodule

// File: tb/tb_spi_sts_sync.sv
// tb_spi_sts_sync: directed scenarios for the status synchroniser with hand-computed expectations
module tb_spi_sts_sync;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        spi_running_in = 1'b0;
    logic [31:0] trig_count_in = '0;
    logic [7:0]  over_thresh_in = '0;
    logic [7:0]  buf_underflow_in = '0;
    logic [7:0]  buf_overflow_in = '0;
    logic        sts_clear = 1'b0;
    logic        spi_running;
    logic [31:0] trig_count;
    logic [7:0]  over_thresh_sticky, buf_underflow_sticky, buf_overflow_sticky;
    logic [1:0]  first_fault_code;
    logic [2:0]  first_fault_ch;
    logic        fault_irq;
    logic [62:0] all_out;
    int          total = 0;
    int          bad = 0;

    spi_sts_sync #(.N_CH(8), .DEPTH(3), .STABLE_COUNT(2)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .spi_running_in(spi_running_in), .trig_count_in(trig_count_in),
        .over_thresh_in(over_thresh_in), .buf_underflow_in(buf_underflow_in),
        .buf_overflow_in(buf_overflow_in), .sts_clear(sts_clear),
        .spi_running(spi_running), .trig_count(trig_count),
        .over_thresh_sticky(over_thresh_sticky), .buf_underflow_sticky(buf_underflow_sticky),
        .buf_overflow_sticky(buf_overflow_sticky), .first_fault_code(first_fault_code),
        .first_fault_ch(first_fault_ch), .fault_irq(fault_irq));

    assign all_out = {spi_running, trig_count, over_thresh_sticky, buf_underflow_sticky,
                      buf_overflow_sticky, first_fault_code, first_fault_ch, fault_irq};

    always #5 aclk = ~aclk;

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic test_reset;
        tick(3);
        total++;
        if (all_out !== 63'd0) begin bad++; $display("FAIL reset_hold got=%h exp=0", all_out); end
        aresetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            total++;
            if (all_out !== 63'd0) begin bad++; $display("FAIL reset_release cyc=%0d got=%h exp=0", i, all_out); end
        end
    endtask

    task automatic test_latency;
        trig_count_in  = 32'h0000_1234;
        spi_running_in = 1'b1;
        tick(6);
        total++;
        if (trig_count !== 32'h0) begin bad++; $display("FAIL count_early got=%h exp=0", trig_count); end
        total++;
        if (spi_running !== 1'b0) begin bad++; $display("FAIL running_early got=%b exp=0", spi_running); end
        tick(1);
        total++;
        if (trig_count !== 32'h0000_1234) begin bad++; $display("FAIL count_latency got=%h exp=00001234", trig_count); end
        total++;
        if (spi_running !== 1'b1) begin bad++; $display("FAIL running_latency got=%b exp=1", spi_running); end
    endtask

    task automatic test_glitch;
        tick(3);
        trig_count_in = 32'hFFFF_FFFF;
        tick(2);
        trig_count_in = 32'h0000_1234;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            total++;
            if (trig_count !== 32'h0000_1234) begin bad++; $display("FAIL glitch cyc=%0d got=%h exp=00001234", i, trig_count); end
        end
    endtask

    task automatic test_underflow;
        buf_underflow_in = 8'h20;
        tick(6);
        total++;
        if ({buf_underflow_sticky, fault_irq} !== 9'h0) begin bad++; $display("FAIL uf_early got=%h/%b exp=0/0", buf_underflow_sticky, fault_irq); end
        tick(1);
        total++;
        if ({buf_underflow_sticky, fault_irq} !== {8'h20, 1'b1}) begin bad++; $display("FAIL uf_set got=%h/%b exp=20/1", buf_underflow_sticky, fault_irq); end
        tick(3);
        buf_underflow_in = 8'h00;
        tick(12);
        total++;
        if (buf_underflow_sticky !== 8'h20) begin bad++; $display("FAIL uf_persist got=%h exp=20", buf_underflow_sticky); end
        total++;
        if ({first_fault_code, first_fault_ch} !== {2'd2, 3'd5}) begin bad++; $display("FAIL uf_first got=%0d/%0d exp=2/5", first_fault_code, first_fault_ch); end
        total++;
        if ({over_thresh_sticky, buf_overflow_sticky, fault_irq} !== {16'h0, 1'b1}) begin bad++; $display("FAIL uf_others got=%h/%h/%b exp=0/0/1", over_thresh_sticky, buf_overflow_sticky, fault_irq); end
    endtask

    task automatic test_clear_zero;
        sts_clear = 1'b1;
        tick(1);
        sts_clear = 1'b0;
        total++;
        if ({over_thresh_sticky, buf_underflow_sticky, buf_overflow_sticky, first_fault_code, first_fault_ch, fault_irq} !== 30'h0) begin
            bad++;
            $display("FAIL clear_zero got=%h/%h/%h/%0d/%0d/%b exp=all 0", over_thresh_sticky, buf_underflow_sticky,
                     buf_overflow_sticky, first_fault_code, first_fault_ch, fault_irq);
        end
    endtask

    task automatic test_priority;
        over_thresh_in  = 8'h0C;
        buf_overflow_in = 8'h01;
        tick(6);
        total++;
        if (fault_irq !== 1'b0) begin bad++; $display("FAIL prio_early got=%b exp=0", fault_irq); end
        tick(1);
        total++;
        if ({over_thresh_sticky, buf_overflow_sticky, fault_irq} !== {8'h0C, 8'h01, 1'b1}) begin bad++; $display("FAIL prio_sticky got=%h/%h/%b exp=0c/01/1", over_thresh_sticky, buf_overflow_sticky, fault_irq); end
        total++;
        if ({first_fault_code, first_fault_ch} !== {2'd1, 3'd2}) begin bad++; $display("FAIL prio_first got=%0d/%0d exp=1/2", first_fault_code, first_fault_ch); end
        buf_underflow_in = 8'h01;
        tick(8);
        total++;
        if (buf_underflow_sticky !== 8'h01) begin bad++; $display("FAIL later_uf got=%h exp=01", buf_underflow_sticky); end
        total++;
        if ({first_fault_code, first_fault_ch} !== {2'd1, 3'd2}) begin bad++; $display("FAIL first_hold got=%0d/%0d exp=1/2", first_fault_code, first_fault_ch); end
    endtask

    task automatic test_clear_high;
        sts_clear = 1'b1;
        tick(1);
        sts_clear = 1'b0;
        total++;
        if ({over_thresh_sticky, buf_underflow_sticky, buf_overflow_sticky, fault_irq} !== {8'h0C, 8'h01, 8'h01, 1'b1}) begin
            bad++;
            $display("FAIL clear_high_sticky got=%h/%h/%h/%b exp=0c/01/01/1", over_thresh_sticky, buf_underflow_sticky, buf_overflow_sticky, fault_irq);
        end
        total++;
        if ({first_fault_code, first_fault_ch} !== {2'd1, 3'd2}) begin bad++; $display("FAIL clear_high_first got=%0d/%0d exp=1/2", first_fault_code, first_fault_ch); end
        over_thresh_in   = 8'h00;
        buf_underflow_in = 8'h00;
        buf_overflow_in  = 8'h00;
        tick(10);
    endtask

    task automatic test_reset_mid;
        over_thresh_in = 8'h80;
        tick(7);
        total++;
        if ({over_thresh_sticky, first_fault_code, first_fault_ch, fault_irq} !== {8'h80, 2'd1, 3'd7, 1'b1}) begin
            bad++;
            $display("FAIL ch7 got=%h/%0d/%0d/%b exp=80/1/7/1", over_thresh_sticky, first_fault_code, first_fault_ch, fault_irq);
        end
        trig_count_in = 32'h0000_5555;
        tick(2);
        #2 aresetn = 1'b0;
        #1;
        total++;
        if (all_out !== 63'd0) begin bad++; $display("FAIL async_reset got=%h exp=0", all_out); end
        over_thresh_in = 8'h00;
        trig_count_in  = 32'h0;
        spi_running_in = 1'b0;
        tick(2);
        total++;
        if (all_out !== 63'd0) begin bad++; $display("FAIL reset_held got=%h exp=0", all_out); end
        aresetn = 1'b1;
        tick(8);
        total++;
        if (all_out !== 63'd0) begin bad++; $display("FAIL after_reset got=%h exp=0", all_out); end
    endtask

    initial begin
        test_reset;
        test_latency;
        test_glitch;
        test_underflow;
        test_clear_zero;
        test_priority;
        test_clear_high;
        test_clear_zero;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
